// File: rtl/weight_config_loader_pkg.sv
// weight_config_loader_pkg
// Shared definitions for the weight/bias configuration loader:
//   - command kind encodings carried in header bits [31:30]
//   - bit positions of the header and count fields
//   - FSM state encoding
//   - small decode helpers used by the loader
package weight_config_loader_pkg;

  // Command kinds; 2'b00 and 2'b11 are rejected as invalid headers.
  localparam logic [1:0] KIND_WEIGHT = 2'b01;
  localparam logic [1:0] KIND_BIAS   = 2'b10;

  // Header word field positions.
  localparam int KIND_MSB   = 31;
  localparam int KIND_LSB   = 30;
  localparam int LAYER_MSB  = 23;
  localparam int LAYER_LSB  = 16;
  localparam int NEURON_MSB = 15;
  localparam int NEURON_LSB = 8;

  // Count word field position and payload counter width.
  localparam int COUNT_MSB   = 15;
  localparam int COUNT_LSB   = 0;
  localparam int COUNT_WIDTH = COUNT_MSB - COUNT_LSB + 1;

  // HDR0: expecting a header word
  // HDR1: expecting the count word
  // LOAD: forwarding payload words onto the neuron bus
  // SKIP: swallowing the payload of a rejected command
  typedef enum logic [1:0] {
    HDR0 = 2'd0,
    HDR1 = 2'd1,
    LOAD = 2'd2,
    SKIP = 2'd3
  } loader_state_t;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] layer;
    logic [7:0] neuron;
  } header_t;

  // Pull the meaningful fields out of a raw header word.
  function automatic header_t decode_header(input logic [31:0] word);
    header_t h;
    h.kind   = word[KIND_MSB:KIND_LSB];
    h.layer  = word[LAYER_MSB:LAYER_LSB];
    h.neuron = word[NEURON_MSB:NEURON_LSB];
    return h;
  endfunction

  function automatic logic kind_is_valid(input logic [1:0] kind);
    return (kind == KIND_WEIGHT) || (kind == KIND_BIAS);
  endfunction

endpackage

// File: rtl/weight_config_loader_if.sv
// weight_config_loader_if
// Host word stream feeding the configuration loader.
//   s_data  : command / payload word from the host
//   s_valid : s_data is valid
//   s_ready : loader accepts s_data this cycle
// Modports:
//   master : host side (DMA or AXI-stream bridge)
//   slave  : loader side
interface weight_config_loader_if;

  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/weight_config_loader.sv
// weight_config_loader
// Configuration master for the neuron array. Parses a host word stream of
// per-neuron load commands (header, count, N payload words) and drives the
// shared weight/bias load bus that every neuron snoops. This block is the
// only writer of that bus.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   host (slave)       : s_data / s_valid / s_ready host stream
//   err_clr            : clears the sticky err flag
//   weightValid        : one-cycle pulse per weight payload word
//   biasValid          : one-cycle pulse per bias payload word
//   weightValue        : registered weight word
//   biasValue          : registered bias word
//   config_layer_num   : target layer of the last valid header, zero-extended
//   config_neuron_num  : target neuron of the last valid header, zero-extended
//   busy               : a command is in progress (state != HDR0)
//   done               : pulses with the final payload pulse of a command
//   err                : sticky flag, set when a rejected header has N > 0
module weight_config_loader
  import weight_config_loader_pkg::*;
#(
  parameter int numLayers  = 4,
  parameter int maxNeurons = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  weight_config_loader_if.slave host,
  input  logic                  err_clr,
  output logic                  weightValid,
  output logic                  biasValid,
  output logic [31:0]           weightValue,
  output logic [31:0]           biasValue,
  output logic [31:0]           config_layer_num,
  output logic [31:0]           config_neuron_num,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [31:0] LAYER_LIMIT  = 32'(numLayers);
  localparam logic [31:0] NEURON_LIMIT = 32'(maxNeurons);

  loader_state_t          state_q;
  loader_state_t          state_d;

  logic                   accept;
  header_t                hdr_in;
  logic                   hdr_in_ok;
  logic [COUNT_WIDTH-1:0] count_in;

  logic [1:0]             kind_q;
  logic [1:0]             kind_d;
  logic                   hdr_ok_q;
  logic                   hdr_ok_d;
  logic [COUNT_WIDTH-1:0] remaining_q;
  logic [COUNT_WIDTH-1:0] remaining_d;

  logic                   weight_valid_d;
  logic                   bias_valid_d;
  logic [31:0]            weight_value_d;
  logic [31:0]            bias_value_d;
  logic [31:0]            layer_num_d;
  logic [31:0]            neuron_num_d;
  logic                   done_d;
  logic                   err_d;

  // The neuron bus never pushes back, so the loader is ready whenever it is
  // out of reset.
  assign host.s_ready = !rst;
  assign accept       = host.s_valid && host.s_ready;

  assign hdr_in    = decode_header(host.s_data);
  assign count_in  = host.s_data[COUNT_MSB:COUNT_LSB];
  assign hdr_in_ok = kind_is_valid(hdr_in.kind)
                     && ({24'd0, hdr_in.layer}  < LAYER_LIMIT)
                     && ({24'd0, hdr_in.neuron} < NEURON_LIMIT);

  assign busy = (state_q != HDR0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HDR0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Every transition is gated by an accepted word; a gap
  // in s_valid simply holds the current state.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        HDR0: state_d = HDR1;
        HDR1: begin
          // A zero-length command finishes immediately, even if its header
          // was rejected, so it never raises err.
          if (count_in == '0) begin
            state_d = HDR0;
          end else if (!hdr_ok_q) begin
            state_d = SKIP;
          end else begin
            state_d = LOAD;
          end
        end
        LOAD, SKIP: begin
          if (remaining_q == COUNT_WIDTH'(1)) begin
            state_d = HDR0;
          end
        end
        default: state_d = HDR0;
      endcase
    end
  end

  // Output / datapath next values. Everything computed here is registered
  // below, so each payload word reaches the bus exactly one cycle after it
  // is accepted.
  always_comb begin
    kind_d         = kind_q;
    hdr_ok_d       = hdr_ok_q;
    remaining_d    = remaining_q;
    weight_valid_d = 1'b0;
    bias_valid_d   = 1'b0;
    weight_value_d = weightValue;
    bias_value_d   = biasValue;
    layer_num_d    = config_layer_num;
    neuron_num_d   = config_neuron_num;
    done_d         = 1'b0;
    // Clear first so that a same-cycle set below takes priority.
    err_d          = err && !err_clr;

    if (accept) begin
      unique case (state_q)
        HDR0: begin
          kind_d   = hdr_in.kind;
          hdr_ok_d = hdr_in_ok;
          // A rejected header must leave the bus target untouched.
          if (hdr_in_ok) begin
            layer_num_d  = {24'd0, hdr_in.layer};
            neuron_num_d = {24'd0, hdr_in.neuron};
          end
        end
        HDR1: begin
          remaining_d = count_in;
          if ((count_in != '0) && !hdr_ok_q) begin
            err_d = 1'b1;
          end
        end
        LOAD: begin
          remaining_d = remaining_q - COUNT_WIDTH'(1);
          if (kind_q == KIND_BIAS) begin
            bias_valid_d = 1'b1;
            bias_value_d = host.s_data;
          end else begin
            weight_valid_d = 1'b1;
            weight_value_d = host.s_data;
          end
          done_d = (remaining_q == COUNT_WIDTH'(1));
        end
        SKIP: begin
          remaining_d = remaining_q - COUNT_WIDTH'(1);
        end
        default: begin
          remaining_d = '0;
        end
      endcase
    end
  end

  // Datapath and output registers. Reset abandons any command in flight;
  // words already issued stay in the neuron memories.
  always_ff @(posedge clk) begin
    if (rst) begin
      kind_q            <= '0;
      hdr_ok_q          <= 1'b0;
      remaining_q       <= '0;
      weightValid       <= 1'b0;
      biasValid         <= 1'b0;
      weightValue       <= '0;
      biasValue         <= '0;
      config_layer_num  <= '0;
      config_neuron_num <= '0;
      done              <= 1'b0;
      err               <= 1'b0;
    end else begin
      kind_q            <= kind_d;
      hdr_ok_q          <= hdr_ok_d;
      remaining_q       <= remaining_d;
      weightValid       <= weight_valid_d;
      biasValid         <= bias_valid_d;
      weightValue       <= weight_value_d;
      biasValue         <= bias_value_d;
      config_layer_num  <= layer_num_d;
      config_neuron_num <= neuron_num_d;
      done              <= done_d;
      err               <= err_d;
    end
  end

endmodule

// File: tb/tb_weight_config_loader.sv
// tb_weight_config_loader
// Self-checking bench for weight_config_loader. Expected bus pulses are
// queued when payload words are driven and checked (kind, value, done and
// exact one-cycle latency) by a monitor when the loader emits them.
module tb_weight_config_loader;
  import weight_config_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        err_clr = 1'b0;
  logic        weightValid;
  logic        biasValid;
  logic [31:0] weightValue;
  logic [31:0] biasValue;
  logic [31:0] config_layer_num;
  logic [31:0] config_neuron_num;
  logic        busy;
  logic        done;
  logic        err;

  weight_config_loader_if host_if ();

  weight_config_loader #(
    .numLayers (4),
    .maxNeurons(64)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .host             (host_if),
    .err_clr          (err_clr),
    .weightValid      (weightValid),
    .biasValid        (biasValid),
    .weightValue      (weightValue),
    .biasValue        (biasValue),
    .config_layer_num (config_layer_num),
    .config_neuron_num(config_neuron_num),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_bias;
    logic [31:0] value;
    bit          last;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;

  // Cycle counter used to check the accept-to-pulse latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every bus pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (weightValid && biasValid) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL both_valid: weightValid=%0b biasValid=%0b, required at most one high", weightValid, biasValid);
      end else if (weightValid || biasValid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_pulse: weightValid=%0b biasValid=%0b at cycle %0d, required no pulse", weightValid, biasValid, cyc);
        end else begin
          e = exp_q.pop_front();
          vectors++;
          if (biasValid !== e.is_bias) begin
            miscompares++;
            $display("[TB] FAIL pulse_kind: biasValid=%0b, required %0b", biasValid, e.is_bias);
          end
          vectors++;
          if ((e.is_bias ? biasValue : weightValue) !== e.value) begin
            miscompares++;
            $display("[TB] FAIL pulse_value: got 0x%08h, required 0x%08h", e.is_bias ? biasValue : weightValue, e.value);
          end
          vectors++;
          if (done !== e.last) begin
            miscompares++;
            $display("[TB] FAIL pulse_done: done=%0b, required %0b", done, e.last);
          end
          vectors++;
          if (cyc !== e.cyc) begin
            miscompares++;
            $display("[TB] FAIL pulse_latency: pulse at cycle %0d, required cycle %0d", cyc, e.cyc);
          end
        end
      end else if (done) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL done_without_pulse: done=1 at cycle %0d, required 0", cyc);
      end
    end
  end

  function automatic logic [31:0] hdr(input logic [1:0] k, input int layer, input int neuron);
    logic [31:0] w;
    w        = '0;
    w[31:30] = k;
    w[23:16] = layer[7:0];
    w[15:8]  = neuron[7:0];
    return w;
  endfunction

  // Drive one word for one cycle; queue its bus pulse if one is expected.
  task automatic drive_word(input logic [31:0] w, input bit pulse, input bit is_bias, input bit last);
    exp_t e;
    @(negedge clk);
    host_if.s_data  = w;
    host_if.s_valid = 1'b1;
    if (pulse) begin
      e.is_bias = is_bias;
      e.value   = w;
      e.last    = last;
      e.cyc     = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      host_if.s_valid = 1'b0;
      host_if.s_data  = '0;
    end
  endtask

  // Bounded wait for all queued pulses to appear.
  task automatic drain(input string name);
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_drain: %0d pulses still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    host_if.s_valid = 1'b0;
    host_if.s_data  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (host_if.s_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready: %0b, required 0", host_if.s_ready); end
    vectors++;
    if ({weightValid, biasValid, done, busy, err} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: wv/bv/done/busy/err=%05b, required 00000", {weightValid, biasValid, done, busy, err});
    end
    vectors++;
    if ({weightValue, biasValue, config_layer_num, config_neuron_num} !== 128'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_values: w=%0h b=%0h l=%0h n=%0h, required all 0", weightValue, biasValue, config_layer_num, config_neuron_num);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (host_if.s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL ready_after_reset: %0b, required 1", host_if.s_ready); end
  endtask

  task automatic test_weight_load();
    drive_word(hdr(KIND_WEIGHT, 1, 3), 0, 0, 0);
    drive_word(32'd4, 0, 0, 0);
    vectors++;
    if (config_layer_num !== 32'd1) begin miscompares++; $display("[TB] FAIL wl_layer: %0d, required 1", config_layer_num); end
    vectors++;
    if (config_neuron_num !== 32'd3) begin miscompares++; $display("[TB] FAIL wl_neuron: %0d, required 3", config_neuron_num); end
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL wl_busy_hdr: %0b, required 1", busy); end
    for (int i = 0; i < 4; i++) drive_word(32'h11 + i, 1, 0, i == 3);
    idle(2);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL wl_busy_end: %0b, required 0", busy); end
    drain("weight_load");
  endtask

  task automatic test_invalid_layer();
    drive_word(hdr(KIND_WEIGHT, 4, 2), 0, 0, 0);
    drive_word(32'd3, 0, 0, 0);
    drive_word(32'hDEAD_0001, 0, 0, 0);
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL inv_err_set: %0b, required 1", err); end
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL inv_busy_skip: %0b, required 1", busy); end
    drive_word(32'hDEAD_0002, 0, 0, 0);
    drive_word(32'hDEAD_0003, 0, 0, 0);
    idle(1);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL inv_busy_end: %0b, required 0", busy); end
    vectors++;
    if ({config_layer_num, config_neuron_num} !== {32'd1, 32'd3}) begin
      miscompares++;
      $display("[TB] FAIL inv_config_kept: layer=%0d neuron=%0d, required 1/3", config_layer_num, config_neuron_num);
    end
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL inv_err_sticky: %0b, required 1", err); end
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL inv_err_clr: %0b, required 0", err); end
    // Neuron out of range, with err_clr high while the count word is taken.
    drive_word(hdr(KIND_BIAS, 0, 64), 0, 0, 0);
    drive_word(32'd1, 0, 0, 0);
    err_clr = 1'b1;
    drive_word(32'hBEEF_0000, 0, 0, 0);
    err_clr = 1'b0;
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL err_set_wins: %0b, required 1", err); end
    idle(1);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL neuron_skip_end: busy=%0b, required 0", busy); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL err_clr_again: %0b, required 0", err); end
    drain("invalid_layer");
  endtask

  task automatic test_bias_load();
    drive_word(hdr(KIND_BIAS, 0, 0), 0, 0, 0);
    drive_word(32'd1, 0, 0, 0);
    drive_word(32'h0000_0100, 1, 1, 1);
    idle(2);
    vectors++;
    if ({config_layer_num, config_neuron_num} !== 64'd0) begin
      miscompares++;
      $display("[TB] FAIL bias_config: layer=%0d neuron=%0d, required 0/0", config_layer_num, config_neuron_num);
    end
    vectors++;
    if (biasValue !== 32'h100) begin miscompares++; $display("[TB] FAIL bias_hold: 0x%08h, required 0x00000100", biasValue); end
    drain("bias_load");
  endtask

  task automatic test_zero_count();
    drive_word(hdr(KIND_WEIGHT, 2, 7), 0, 0, 0);
    drive_word(32'd0, 0, 0, 0);
    vectors++;
    if ({config_layer_num, config_neuron_num} !== {32'd2, 32'd7}) begin
      miscompares++;
      $display("[TB] FAIL zero_config: layer=%0d neuron=%0d, required 2/7", config_layer_num, config_neuron_num);
    end
    drive_word(hdr(KIND_WEIGHT, 3, 9), 0, 0, 0);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_back_to_hdr0: busy=%0b, required 0", busy); end
    drive_word(32'd2, 0, 0, 0);
    drive_word(32'h0000_00A1, 1, 0, 0);
    drive_word(32'h0000_00A2, 1, 0, 1);
    idle(2);
    vectors++;
    if ({config_layer_num, config_neuron_num} !== {32'd3, 32'd9}) begin
      miscompares++;
      $display("[TB] FAIL zero_next_config: layer=%0d neuron=%0d, required 3/9", config_layer_num, config_neuron_num);
    end
    drain("zero_count");
  endtask

  task automatic test_gapped();
    drive_word(hdr(KIND_WEIGHT, 1, 1), 0, 0, 0);
    drive_word(32'd5, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive_word(32'h200 + i, 1, 0, i == 4);
      idle(1);
    end
    idle(1);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL gap_busy_end: %0b, required 0", busy); end
    drain("gapped");
  endtask

  task automatic test_reset_mid();
    drive_word(hdr(KIND_WEIGHT, 2, 4), 0, 0, 0);
    drive_word(32'd5, 0, 0, 0);
    drive_word(32'h0000_0301, 1, 0, 0);
    drive_word(32'h0000_0302, 1, 0, 0);
    @(negedge clk);
    #1;
    rst             = 1'b1;
    host_if.s_valid = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if ({weightValid, biasValid, done, busy, err} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_flags: wv/bv/done/busy/err=%05b, required 00000", {weightValid, biasValid, done, busy, err});
    end
    vectors++;
    if ({weightValue, config_layer_num, config_neuron_num} !== 96'd0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_values: w=%0h l=%0h n=%0h, required all 0", weightValue, config_layer_num, config_neuron_num);
    end
    rst = 1'b0;
    drive_word(hdr(KIND_BIAS, 2, 5), 0, 0, 0);
    drive_word(32'd1, 0, 0, 0);
    vectors++;
    if ({config_layer_num, config_neuron_num} !== {32'd2, 32'd5}) begin
      miscompares++;
      $display("[TB] FAIL rstmid_header: layer=%0d neuron=%0d, required 2/5", config_layer_num, config_neuron_num);
    end
    drive_word(32'h0000_0055, 1, 1, 1);
    idle(2);
    drain("reset_mid");
  endtask

  // Safety net: the bench must always terminate.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    host_if.s_valid = 1'b0;
    host_if.s_data  = '0;
    test_reset();
    test_weight_load();
    test_invalid_layer();
    test_bias_load();
    test_zero_count();
    test_gapped();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/weight_config_loader.md
# weight_config_loader

Configuration master for the network's neuron array. It accepts a host word stream, parses per-neuron load commands, and drives the shared weight/bias load bus that every neuron snoops: weightValid, biasValid, weightValue, biasValue, config_layer_num and config_neuron_num. It sits between the host interface (DMA or AXI-stream bridge) and all layer instances, and is the only writer of that bus.

## Interface
Parameters:
- numLayers, 4, number of layers; a header layer field >= numLayers is an error.
- maxNeurons, 64, a header neuron field >= maxNeurons is an error.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- s_data  in  32  host command/payload word.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts s_data this cycle.
- err_clr  in  1  clears the sticky err flag.
- weightValid  out  1  one-cycle pulse per weight word.
- biasValid  out  1  one-cycle pulse per bias word.
- weightValue  out  32  weight word; neurons use the low dataWidth bits.
- biasValue  out  32  bias word.
- config_layer_num  out  32  target layer, zero-extended.
- config_neuron_num  out  32  target neuron, zero-extended.
- busy  out  1  command in progress (state != HDR0).
- done  out  1  one-cycle pulse when the last payload word of a command is issued.
- err  out  1  sticky error flag.

## Operation
- A word is accepted on a cycle where s_valid & s_ready. s_ready = !rst in every state, so there is no backpressure from the neuron bus.
- Command format:
  - Word 0 header: [31:30] kind (01 weights, 10 bias, 00/11 invalid), [23:16] layer, [15:8] neuron, other bits ignored.
  - Word 1: [15:0] count N.
  - Then N payload words.
- FSM states: HDR0, HDR1, LOAD, SKIP.
- HDR0:
  - On accept, latch kind, layer and neuron.
  - A valid header updates config_layer_num and config_neuron_num on the next edge.
  - Always go to HDR1.
- HDR1: on accept, load the remaining counter with N.
  - N == 0: go to HDR0, no pulses, no done.
  - Header invalid (bad kind, layer >= numLayers, or neuron >= maxNeurons): set err, go to SKIP.
  - Otherwise go to LOAD.
- LOAD: each accepted word produces a registered copy on weightValue or biasValue and a one-cycle weightValid or biasValid pulse, selected by kind.
  - Decrement remaining on each accepted word.
  - On the word where remaining == 1: pulse done together with the last valid pulse, then go to HDR0.
- SKIP: consume N words with no bus activity and no done, then go to HDR0.
- Bias commands with N > 1 issue N biasValid pulses; the neuron keeps the last value.
- config_layer_num and config_neuron_num hold between commands; an invalid header leaves them unchanged.
- err: set in HDR1 on an invalid header, cleared by err_clr. If set and clear occur in the same cycle, set wins.
- Reset values: all outputs 0, state HDR0, counter 0.
- Reset mid-command: abandon the command and return to HDR0. Words already issued stay in the neuron memories. The host must then reset the neurons or reload the command.

## Timing
- Every output is registered. Latency from accepted payload word to its valid pulse is exactly 1 cycle.
- config_layer_num and config_neuron_num change 1 cycle after the header is accepted, which is at least 2 cycles before the first payload pulse.
- Payload throughput is 1 word per cycle. Gaps in s_valid produce gaps in the pulses; there is no buffering.
- weightValid and biasValid are never high together.
- done coincides with the final valid pulse.

## Structure
- Shared package holds:
  - kind encodings: KIND_WEIGHT = 2'b01, KIND_BIAS = 2'b10;
  - header field bit positions;
  - FSM state encoding.
- Single flat module, no sub-module. The counter is 16 bits.

## Test plan
- Weight load: header kind 01, layer 1, neuron 3, N = 4, words 0x11..0x14 streamed back-to-back -> config_layer_num = 1 and config_neuron_num = 3; four consecutive weightValid pulses carrying 0x11..0x14; done on the 4th pulse; busy low next cycle.
- Bias load: kind 10, layer 0, neuron 0, N = 1, word 0x0000_0100 -> a single biasValid with biasValue = 0x100, weightValid never high, done asserted.
- Invalid layer: layer = numLayers, N = 3 -> err set, 3 words consumed with no valid pulses and no done, config numbers unchanged; err_clr clears err.
- N = 0 followed by a valid 2-word weight command -> the first command produces no pulses; the second is parsed correctly.
- s_valid toggling every other cycle during a 5-word load -> 5 pulses, each 1 cycle after its accept, in the same gapped pattern.
- rst asserted after 2 of 5 payload words -> outputs 0 next cycle, state HDR0; the next word is parsed as a header.
